bcd_counter_ctrl: RTL

Command-side controller for a chain of DIGITS cascaded BCD functional counters. It turns single-cycle key events into the chain's one-hot mode word, preset bus and least-significant-digit count enable (bcin). It watches the most-significant digit's carry/borrow to report wrap.
It sits between the keypad decoder and the counter chain in the keyboard example.

---
 rtl/bcd_counter_ctrl.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/bcd_counter_ctrl.sv
// bcd_counter_ctrl: command-side controller for a chain of DIGITS cascaded BCD
// counters. Turns single-cycle key events into the chain's one-hot mode word,
// preset bus and digit-0 count enable, and watches the MSD carry/borrow to
// report wrap-around.
//
// Ports:
//   clk, rst    : rising-edge clock, asynchronous active-high reset
//   key_valid   : one-cycle key strobe; key_code valid in the same cycle
//   key_code    : 0-9 digit, 10 LOAD, 11 CLR, 12 UP, 13 DOWN, 14 STOP, 15 ignored
//   mode        : 0001 preset, 0010 clear, 0100 up, 1000 down, 0000 hold
//   BCD_preset  : preset value, digit 0 in bits [3:0]
//   bcin        : count enable into digit 0 (single-cycle pulse per tick)
//   bcout_msd   : carry/borrow out of the most-significant digit
//   entry       : keypad entry buffer, for display
//   running     : high while counting up or down
//   wrap_flag   : sticky wrap indicator
module bcd_counter_ctrl #(
  parameter int DIGITS    = 4,
  parameter int TICK_DIV  = 50000000,
  parameter int WRAP_STOP = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  key_valid,
  input  logic [3:0]            key_code,
  output logic [3:0]            mode,
  output logic [4*DIGITS-1:0]   BCD_preset,
  output logic                  bcin,
  input  logic                  bcout_msd,
  output logic [4*DIGITS-1:0]   entry,
  output logic                  running,
  output logic                  wrap_flag
);

  localparam int W  = 4 * DIGITS;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_PRESET   = 3'd1;
  localparam logic [2:0] S_CLEAR    = 3'd2;
  localparam logic [2:0] S_RUN_UP   = 3'd3;
  localparam logic [2:0] S_RUN_DOWN = 3'd4;

  localparam logic [3:0] K_LOAD = 4'd10;
  localparam logic [3:0] K_CLR  = 4'd11;
  localparam logic [3:0] K_UP   = 4'd12;
  localparam logic [3:0] K_DOWN = 4'd13;
  localparam logic [3:0] K_STOP = 4'd14;

  logic [2:0]    state_q, state_d;
  logic [3:0]    mode_q, mode_d;
  logic [W-1:0]  preset_q, preset_d;
  logic [W-1:0]  entry_q, entry_d;
  logic          bcin_q, bcin_d;
  logic          running_q, running_d;
  logic          wrap_q, wrap_d;
  logic [TW-1:0] tick_q, tick_d;

  logic is_cmd, is_digit, wrap_hit, run_d;

  always_comb begin
    state_d  = state_q;
    entry_d  = entry_q;
    preset_d = preset_q;
    wrap_d   = wrap_q;
    tick_d   = tick_q;
    bcin_d   = 1'b0;
    is_cmd   = key_valid && (key_code >= K_LOAD) && (key_code <= K_STOP);
    is_digit = key_valid && (key_code <= 4'd9);
    // bcout_msd is only meaningful while our own pulse is on the chain
    wrap_hit = bcin_q && bcout_msd;

    case (state_q)
      S_IDLE: begin
        if (is_digit) entry_d = (entry_q << 4) | W'(key_code);
        if (is_cmd) begin
          wrap_d = 1'b0;
          case (key_code)
            K_LOAD: begin preset_d = entry_q; state_d = S_PRESET; end
            K_CLR:  begin entry_d = '0; state_d = S_CLEAR; end
            K_UP:   state_d = S_RUN_UP;
            K_DOWN: state_d = S_RUN_DOWN;
            default: ;
          endcase
        end
      end
      S_PRESET: begin
        entry_d = '0;
        state_d = S_IDLE;
      end
      S_CLEAR: state_d = S_IDLE;
      S_RUN_UP, S_RUN_DOWN: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          bcin_d = 1'b1;
        end else begin
          tick_d = tick_q + TW'(1);
        end
        if (wrap_hit && (WRAP_STOP != 0)) state_d = S_IDLE;
        // a key overrides the wrap-stop transition; LOAD is ignored here
        if (is_cmd) begin
          case (key_code)
            K_UP:   begin state_d = S_RUN_UP;   tick_d = '0; bcin_d = 1'b0; wrap_d = 1'b0; end
            K_DOWN: begin state_d = S_RUN_DOWN; tick_d = '0; bcin_d = 1'b0; wrap_d = 1'b0; end
            K_STOP: begin state_d = S_IDLE;  wrap_d = 1'b0; end
            K_CLR:  begin state_d = S_CLEAR; wrap_d = 1'b0; end
            default: ;
          endcase
        end
        // a wrap seen in the same cycle as a command is still recorded
        if (wrap_hit) wrap_d = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    run_d = (state_d == S_RUN_UP) || (state_d == S_RUN_DOWN);
    if (!run_d) begin
      bcin_d = 1'b0;
      tick_d = '0;
    end
    running_d = run_d;

    case (state_d)
      S_PRESET:   mode_d = 4'b0001;
      S_CLEAR:    mode_d = 4'b0010;
      S_RUN_UP:   mode_d = 4'b0100;
      S_RUN_DOWN: mode_d = 4'b1000;
      default:    mode_d = 4'b0000;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mode_q    <= '0;
      preset_q  <= '0;
      entry_q   <= '0;
      bcin_q    <= 1'b0;
      running_q <= 1'b0;
      wrap_q    <= 1'b0;
      tick_q    <= '0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      preset_q  <= preset_d;
      entry_q   <= entry_d;
      bcin_q    <= bcin_d;
      running_q <= running_d;
      wrap_q    <= wrap_d;
      tick_q    <= tick_d;
    end
  end

  assign mode       = mode_q;
  assign BCD_preset = preset_q;
  assign entry      = entry_q;
  assign bcin       = bcin_q;
  assign running    = running_q;
  assign wrap_flag  = wrap_q;

endmodule
